// File: rtl/spi_burst_ram_if.sv
// Command/response bus between the SPI slave front end and the burst RAM.
interface spi_burst_ram_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH+1:0] din;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  tx_valid;
  logic                  err;

  modport master (output din, output rx_valid, input dout, input tx_valid, input err);
  modport slave  (input din, input rx_valid, output dout, output tx_valid, output err);
endinterface

// File: rtl/spi_burst_ram.sv
// Single-port RAM slave decoding 2-bit command prefixes, with optional burst
// address auto-increment (wrapping at MEM_DEPTH-1) and an error pulse.
module spi_burst_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_burst_ram_if.slave  bus
);

  typedef enum logic [1:0] {
    CMD_WADDR = 2'b00,
    CMD_WDATA = 2'b01,
    CMD_RADDR = 2'b10,
    CMD_RDATA = 2'b11
  } cmd_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0]  wr_addr;
  logic [ADDR_SIZE-1:0]  rd_addr;
  logic                  wr_armed;
  logic                  rd_armed;

  cmd_e                  cmd;
  logic [ADDR_SIZE-1:0]  a;
  logic [DATA_WIDTH-1:0] d;
  logic                  a_ok;

  assign cmd  = cmd_e'(bus.din[DATA_WIDTH+1:DATA_WIDTH]);
  assign a    = bus.din[ADDR_SIZE-1:0];
  assign d    = bus.din[DATA_WIDTH-1:0];
  assign a_ok = int'(a) < MEM_DEPTH;

  // Post-access pointer update; holds the pointer when auto-increment is off.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] p);
    if (AUTO_INC == 0)
      return p;
    if (int'(p) == MEM_DEPTH - 1)
      return '0;
    return p + ADDR_SIZE'(1);
  endfunction

  // Storage is never reset; a write is blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && bus.rx_valid && cmd == CMD_WDATA && wr_armed)
      mem[wr_addr] <= d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.dout     <= '0;
      bus.tx_valid <= 1'b0;
      bus.err      <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      wr_armed     <= 1'b0;
      rd_armed     <= 1'b0;
    end else begin
      bus.tx_valid <= 1'b0;
      bus.err      <= 1'b0;
      if (bus.rx_valid) begin
        case (cmd)
          CMD_WADDR: begin
            if (a_ok) begin
              wr_addr  <= a;
              wr_armed <= 1'b1;
            end else begin
              bus.err <= 1'b1;
            end
          end
          CMD_WDATA: begin
            if (wr_armed)
              wr_addr <= next_addr(wr_addr);
            else
              bus.err <= 1'b1;
          end
          CMD_RADDR: begin
            if (a_ok) begin
              rd_addr  <= a;
              rd_armed <= 1'b1;
            end else begin
              bus.err <= 1'b1;
            end
          end
          CMD_RDATA: begin
            if (rd_armed) begin
              bus.dout     <= mem[rd_addr];
              bus.tx_valid <= 1'b1;
              rd_addr      <= next_addr(rd_addr);
            end else begin
              bus.err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed and randomised checks of spi_burst_ram in three configurations.
module tb_spi_burst_ram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_burst_ram_if #(.DATA_WIDTH(8)) if_a ();
  spi_burst_ram_if #(.DATA_WIDTH(8)) if_b ();
  spi_burst_ram_if #(.DATA_WIDTH(8)) if_c ();

  spi_burst_ram #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  spi_burst_ram #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(200), .AUTO_INC(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  spi_burst_ram #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    if_a.rx_valid = 1'b0; if_a.din = '0;
    if_b.rx_valid = 1'b0; if_b.din = '0;
    if_c.rx_valid = 1'b0; if_c.din = '0;
  endtask

  // Presents one command to the selected DUT for one edge, then samples 1 ns later.
  task automatic send(input int u, input logic [1:0] c, input logic [7:0] p);
    idle_all();
    case (u)
      0: begin if_a.rx_valid = 1'b1; if_a.din = {c, p}; end
      1: begin if_b.rx_valid = 1'b1; if_b.din = {c, p}; end
      default: begin if_c.rx_valid = 1'b1; if_c.din = {c, p}; end
    endcase
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic tick();
    idle_all();
    @(posedge clk); #1;
  endtask

  logic [7:0] m_mem [256];
  logic [7:0] m_wa, m_ra, m_dout;
  logic       m_warm, m_rarm, m_tx, m_err;

  initial begin
    idle_all();
    rst_n = 1'b0;
    tick(); tick();
    chk8("reset_dout", if_a.dout, 8'h00);
    chk1("reset_tx", if_a.tx_valid, 1'b0);
    chk1("reset_err", if_a.err, 1'b0);
    rst_n = 1'b1;

    // Data commands before any address are rejected
    send(0, 2'b01, 8'h77);
    chk1("unarmed_wr_err", if_a.err, 1'b1);
    chk8("unarmed_wr_ptr", dut_a.wr_addr, 8'h00);
    send(0, 2'b11, 8'h00);
    chk1("unarmed_rd_err", if_a.err, 1'b1);
    chk1("unarmed_rd_tx", if_a.tx_valid, 1'b0);
    chk8("unarmed_rd_dout", if_a.dout, 8'h00);

    // Basic write/read
    send(0, 2'b00, 8'h0A);
    chk1("waddr_err", if_a.err, 1'b0);
    send(0, 2'b01, 8'hF5);
    send(0, 2'b10, 8'h0A);
    send(0, 2'b11, 8'h55);
    chk8("basic_dout", if_a.dout, 8'hF5);
    chk1("basic_tx", if_a.tx_valid, 1'b1);
    chk1("basic_err", if_a.err, 1'b0);
    tick();
    chk1("basic_tx_drop", if_a.tx_valid, 1'b0);
    chk8("basic_dout_hold", if_a.dout, 8'hF5);

    // Burst with wrap at top of memory
    send(0, 2'b00, 8'hFE);
    send(0, 2'b01, 8'h11);
    send(0, 2'b01, 8'h22);
    send(0, 2'b01, 8'h33);
    chk1("wrap_wr_err", if_a.err, 1'b0);
    send(0, 2'b10, 8'hFE);
    send(0, 2'b11, 8'h00);
    chk8("burst_rd0", if_a.dout, 8'h11);
    chk1("burst_tx0", if_a.tx_valid, 1'b1);
    send(0, 2'b11, 8'h00);
    chk8("burst_rd1", if_a.dout, 8'h22);
    chk1("burst_tx1", if_a.tx_valid, 1'b1);
    send(0, 2'b11, 8'h00);
    chk8("burst_rd2", if_a.dout, 8'h33);
    chk1("burst_tx2", if_a.tx_valid, 1'b1);
    chk1("burst_err2", if_a.err, 1'b0);

    // Read of the word written on the previous edge
    send(0, 2'b10, 8'h30);
    send(0, 2'b00, 8'h30);
    send(0, 2'b01, 8'h6D);
    send(0, 2'b11, 8'h00);
    chk8("rdw_dout", if_a.dout, 8'h6D);

    // MEM_DEPTH = 200 range checks
    send(1, 2'b00, 8'hC8);
    chk1("range_wa_err", if_b.err, 1'b1);
    chk8("range_wa_ptr", dut_b.wr_addr, 8'h00);
    send(1, 2'b00, 8'hC7);
    chk1("range_ok_err", if_b.err, 1'b0);
    send(1, 2'b01, 8'hAA);
    send(1, 2'b01, 8'hBB);
    send(1, 2'b10, 8'hC8);
    chk1("range_ra_err", if_b.err, 1'b1);
    send(1, 2'b10, 8'hC7);
    send(1, 2'b11, 8'h00);
    chk8("d200_top", if_b.dout, 8'hAA);
    send(1, 2'b11, 8'h00);
    chk8("d200_wrap", if_b.dout, 8'hBB);
    chk1("d200_wrap_err", if_b.err, 1'b0);

    // AUTO_INC = 0 keeps hitting the same word
    send(2, 2'b00, 8'h05);
    send(2, 2'b01, 8'h01);
    send(2, 2'b01, 8'h02);
    send(2, 2'b10, 8'h05);
    send(2, 2'b11, 8'h00);
    chk8("noinc_rd0", if_c.dout, 8'h02);
    send(2, 2'b11, 8'h00);
    chk8("noinc_rd1", if_c.dout, 8'h02);
    chk1("noinc_tx1", if_c.tx_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("idle_tx", if_c.tx_valid, 1'b0);
      chk1("idle_err", if_c.err, 1'b0);
    end
    chk8("idle_dout", if_c.dout, 8'h02);
    chk8("idle_wa", dut_c.wr_addr, 8'h05);
    chk8("idle_ra", dut_c.rd_addr, 8'h05);

    // Reset mid-burst, with a write presented during reset
    send(0, 2'b00, 8'h10);
    send(0, 2'b01, 8'hA1);
    send(0, 2'b01, 8'hA2);
    rst_n = 1'b0;
    send(0, 2'b01, 8'hA3);
    chk8("midrst_dout", if_a.dout, 8'h00);
    chk1("midrst_tx", if_a.tx_valid, 1'b0);
    chk1("midrst_err", if_a.err, 1'b0);
    rst_n = 1'b1;
    send(0, 2'b01, 8'hA4);
    chk1("abandoned_err", if_a.err, 1'b1);
    send(0, 2'b10, 8'h10);
    send(0, 2'b11, 8'h00);
    chk8("kept_rd0", if_a.dout, 8'hA1);
    send(0, 2'b11, 8'h00);
    chk8("kept_rd1", if_a.dout, 8'hA2);
    send(0, 2'b11, 8'h00);
    chk1("kept_rd2_tx", if_a.tx_valid, 1'b1);
    chk1("rst_prio_nowrite", if_a.dout === 8'hA3, 1'b0);

    // Random phase: fill memory with a known pattern, then compare against a model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(0, 2'b00, 8'h00);
    for (int i = 0; i < 256; i++) begin
      send(0, 2'b01, 8'(i) ^ 8'h5A);
      m_mem[i] = 8'(i) ^ 8'h5A;
    end
    m_wa = 8'h00; m_ra = 8'h00; m_warm = 1'b1; m_rarm = 1'b0;
    m_dout = 8'h00; m_tx = 1'b0; m_err = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      logic       r_rst, r_vld;
      logic [9:0] r_din;
      r_rst = ($urandom_range(0, 99) == 0);
      r_vld = ($urandom_range(0, 3) != 0);
      r_din = 10'($urandom);
      idle_all();
      rst_n = ~r_rst;
      if_a.rx_valid = r_vld;
      if_a.din = r_din;
      if (r_rst) begin
        m_wa = 8'h00; m_ra = 8'h00; m_warm = 1'b0; m_rarm = 1'b0;
        m_dout = 8'h00; m_tx = 1'b0; m_err = 1'b0;
      end else begin
        m_tx = 1'b0; m_err = 1'b0;
        if (r_vld) begin
          case (r_din[9:8])
            2'b00: begin m_wa = r_din[7:0]; m_warm = 1'b1; end
            2'b01: begin
              if (m_warm) begin m_mem[m_wa] = r_din[7:0]; m_wa = m_wa + 8'd1; end
              else m_err = 1'b1;
            end
            2'b10: begin m_ra = r_din[7:0]; m_rarm = 1'b1; end
            default: begin
              if (m_rarm) begin m_dout = m_mem[m_ra]; m_tx = 1'b1; m_ra = m_ra + 8'd1; end
              else m_err = 1'b1;
            end
          endcase
        end
      end
      @(posedge clk); #1;
      chk8("rand_dout", if_a.dout, m_dout);
      chk1("rand_tx", if_a.tx_valid, m_tx);
      chk1("rand_err", if_a.err, m_err);
    end
    rst_n = 1'b1;
    idle_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_ram.md
# spi_burst_ram

Parametrised single-port synchronous RAM slave behind the SPI slave front end. It decodes the 2-bit command prefix on each received word into write-address, write-data, read-address and read-data operations. Relative to the fixed 256x8 RAM, it adds:
- configurable data width, address width and depth;
- optional address auto-increment for burst transfers, with wrap-around at the top of memory;
- an error pulse for out-of-range addresses and for data commands issued before an address.

## Interface
Parameters:
- DATA_WIDTH, 8, width of data words and of the din payload field.
- ADDR_SIZE, 8, address register width; must satisfy ADDR_SIZE <= DATA_WIDTH.
- MEM_DEPTH, 256, number of words; must satisfy 2 <= MEM_DEPTH <= 2**ADDR_SIZE.
- AUTO_INC, 1, 1 = post-increment the address after each data command, 0 = hold the address.

Ports:
- clk, input, 1, system clock; everything is sampled on the rising edge.
- rst_n, input, 1, reset; synchronous and active-low.
- din, input, DATA_WIDTH+2, din[DATA_WIDTH+1:DATA_WIDTH] is the command and din[DATA_WIDTH-1:0] is the payload.
- rx_valid, input, 1, din is valid this cycle.
- dout, output, DATA_WIDTH, read data; holds its value until the next read.
- tx_valid, output, 1, one-cycle pulse marking new dout.
- err, output, 1, one-cycle pulse on a rejected command.

## Operation
- Internal state:
  - wr_addr and rd_addr, ADDR_SIZE bits each;
  - wr_armed and rd_armed flags;
  - mem[MEM_DEPTH], which is not reset.
- Reset (rst_n low at an edge):
  - outputs: dout=0, tx_valid=0, err=0;
  - wr_addr=0, rd_addr=0, wr_armed=0, rd_armed=0;
  - mem contents are kept.
  - A reset in the middle of a burst abandons the burst; a new address command is required afterwards.
- With rx_valid=0 there is no state change; tx_valid and err are 0 at the next edge.
- With rx_valid=1, where a = din[ADDR_SIZE-1:0] and d = din[DATA_WIDTH-1:0]:
  - 00 write-address: if a < MEM_DEPTH, then wr_addr<=a and wr_armed<=1. Otherwise err pulses and wr_addr/wr_armed are unchanged.
  - 01 write-data:
    - If wr_armed, then mem[wr_addr]<=d. If AUTO_INC, also wr_addr<=(wr_addr==MEM_DEPTH-1)?0:wr_addr+1.
    - If not wr_armed, the write is dropped and err pulses.
  - 10 read-address: if a < MEM_DEPTH, then rd_addr<=a and rd_armed<=1. Otherwise err pulses.
  - 11 read-data (payload ignored):
    - If rd_armed, then dout<=mem[rd_addr] and tx_valid<=1. If AUTO_INC, rd_addr wraps in the same way as wr_addr.
    - If not rd_armed, dout is unchanged, tx_valid=0 and err pulses.
- Payload bits above ADDR_SIZE-1 are ignored for address commands.
- Write and read pointers are independent. The armed flags stay set until reset, so repeated data commands with AUTO_INC=0 target the same word.

## Timing
- All effects are registered and take effect at the edge where rx_valid=1 is sampled.
  - For a read-data command sampled at edge k, dout and tx_valid are valid from edge k until edge k+1.
  - tx_valid is high for exactly one cycle per accepted read; back-to-back reads give consecutive pulses.
- A write-data at edge k followed by a read-data of the same address at edge k+1 returns the newly written word; there is no read-during-write hazard.
- Wrap-around: after an access at MEM_DEPTH-1 with AUTO_INC=1, the next data command uses address 0, and err is not raised.
- err is high for one cycle after each rejected command and is never combined with a tx_valid pulse.
- Reset has priority over any command in the same cycle.

## Test plan
- Defaults: 00/0x0A, then 01/0xF5, then 10/0x0A, then 11/0x55 -> dout=0xF5 with a tx_valid pulse on the cycle after the fourth command; err stays 0.
- AUTO_INC=1: write-address 0xFE, then data 0x11, 0x22, 0x33; read-address 0xFE, then three read-data commands -> dout sequence 0x11, 0x22, 0x33 (the third word is at address 0x00), tx_valid high for 3 consecutive cycles.
- MEM_DEPTH=200: 00/0xC8 -> err pulse, wr_addr unchanged. Then 00/0xC7, then 01/0xAA, 01/0xBB -> mem[0xC7]=0xAA and mem[0x00]=0xBB.
- After reset: 01/0x77 -> err pulse and memory unchanged. 11 -> err pulse, tx_valid=0, dout=0.
- AUTO_INC=0: 00/0x05, then 01/0x01 and 01/0x02 -> mem[5]=0x02. With rx_valid=0 for 10 cycles -> outputs and pointers unchanged.
- Reset mid-burst after two writes -> outputs zero; previously written words are still readable after a new 10 command.
- Random: 3000 cycles of random din and rx_valid, checked against a reference model of mem, pointers, dout, tx_valid and err.
